// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding, counter width.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/sub_op.sv
// Subtractor diff = a + ~b + 1 built on the ALU adder's generate/propagate carry chain.
module sub_op #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a_i & ~b_i;
  assign p = a_i ^ ~b_i;

  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff_o   = p ^ c[WIDTH-1:0];
  // No carry out of an a + ~b + 1 chain means a < b as unsigned values.
  assign borrow_o = ~c[WIDTH];

endmodule

// File: rtl/div_op.sv
// Multi-cycle signed restoring divider: quotient to LO, remainder to HI.
module div_op
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted, trial;
  logic             trial_borrow;
  logic [WIDTH-1:0] neg0_in, neg1_in, neg0, neg1;
  logic             neg0_borrow, neg1_borrow;
  logic             unused_bits;

  assign shifted = {rem_q, q_q[WIDTH-1]};

  sub_op #(.WIDTH(WIDTH + 1)) u_trial (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (trial),
    .borrow_o (trial_borrow)
  );

  // Two negators shared: operand magnitudes in IDLE, result sign fix-up in FIX.
  assign neg0_in = (state_q == FIX) ? q_q   : A_reg;
  assign neg1_in = (state_q == FIX) ? rem_q : B_reg;

  sub_op #(.WIDTH(WIDTH)) u_neg0 (
    .a_i      ('0),
    .b_i      (neg0_in),
    .diff_o   (neg0),
    .borrow_o (neg0_borrow)
  );

  sub_op #(.WIDTH(WIDTH)) u_neg1 (
    .a_i      ('0),
    .b_i      (neg1_in),
    .diff_o   (neg1),
    .borrow_o (neg1_borrow)
  );

  assign unused_bits = neg0_borrow ^ neg1_borrow ^ trial[WIDTH];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgn_q_d = A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
          sgn_r_d = A_reg[WIDTH-1];
          q_d     = A_reg[WIDTH-1] ? neg0 : A_reg;
          dvs_d   = B_reg[WIDTH-1] ? neg1 : B_reg;
          rem_d   = '0;
          cnt_d   = '0;
          if (B_reg == '0) begin
            quot_d  = '1;
            remo_d  = A_reg;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // The partial remainder stays below the divisor, so its top bit is always 0.
        if (!trial_borrow) begin
          rem_d = trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = sgn_q_q ? neg0 : q_q;
        remo_d  = sgn_r_q ? neg1 : rem_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q == CALC) || (state_q == FIX);
  assign done          = (state_q == DONE);
  assign div_by_zero   = dbz_q;
  assign quotient_out  = quot_q;
  assign remainder_out = remo_q;

endmodule

// File: tb/tb_div_op.sv
// Directed-vector bench for div_op: results, latency, handshake, reset abort.
module tb_div_op;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [31:0] A_reg, B_reg;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient_out, remainder_out;

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  div_op #(.WIDTH(32)) dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .start         (start),
    .A_reg         (A_reg),
    .B_reg         (B_reg),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    A_reg = a;
    B_reg = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    A_reg = $urandom;
    B_reg = $urandom;
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_edges, input logic [31:0] q, input logic [31:0] r,
                        input logic dbz);
    int edges;
    launch(a, b);
    edges = 1;
    if (exp_edges > 1) chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    while (!done && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    chk({tag, ".lat"}, edges, exp_edges);
    chk({tag, ".q"}, quotient_out, q);
    chk({tag, ".r"}, remainder_out, r);
    chk({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, dbz});
    @(negedge clock);
    chk({tag, ".pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    clear_n = 1'b0;
    start   = 1'b0;
    A_reg   = '0;
    B_reg   = '0;
    repeat (2) @(negedge clock);
    chk("rst.outs", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("rst.q", quotient_out, 32'd0);
    chk("rst.r", remainder_out, 32'd0);
    clear_n = 1'b1;

    do_div("p100_7",  32'd100,       32'd7,          34, 32'd14,        32'd2,        1'b0);
    do_div("n100_7",  -32'sd100,     32'd7,          34, 32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0);
    do_div("p100_n7", 32'd100,       -32'sd7,        34, 32'hFFFFFFF2,  32'd2,        1'b0);
    do_div("n100_n7", -32'sd100,     -32'sd7,        34, 32'd14,        32'hFFFFFFFE, 1'b0);
    do_div("5_0",     32'd5,         32'd0,          1,  32'hFFFFFFFF,  32'd5,        1'b1);
    do_div("9_3",     32'd9,         32'd3,          34, 32'd3,         32'd0,        1'b0);
    do_div("min_n1",  32'h80000000,  32'hFFFFFFFF,   34, 32'h80000000,  32'd0,        1'b0);
    do_div("min_1",   32'h80000000,  32'd1,          34, 32'h80000000,  32'd0,        1'b0);
    do_div("max_max", 32'h7FFFFFFF,  32'h7FFFFFFF,   34, 32'd1,         32'd0,        1'b0);

    // Start during CALC is ignored; outputs keep the previous result mid-run.
    d0 = ndone;
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    chk("ign.hold_q", quotient_out, 32'd1);
    A_reg = 32'd8;
    B_reg = 32'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    chk("ign.q", quotient_out, 32'd333);
    chk("ign.r", remainder_out, 32'd1);
    repeat (40) @(negedge clock);
    chk("ign.ndone", ndone - d0, 32'd1);

    // Asynchronous reset mid-division aborts it without a done pulse.
    d0 = ndone;
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("abort.flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("abort.q", quotient_out, 32'd0);
    chk("abort.r", remainder_out, 32'd0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort.ndone", ndone - d0, 32'd0);
    do_div("8_2", 32'd8, 32'd2, 34, 32'd4, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
